// File: rtl/mmio_spi_pkg.sv
// Shared register-map indices, STATUS bit positions and frame-state type
// for the memory-mapped SPI slave.
package mmio_spi_pkg;

  localparam logic [1:0] TXDATA = 2'd0;
  localparam logic [1:0] RXDATA = 2'd1;
  localparam logic [1:0] STATUS = 2'd2;

  localparam int RXV = 0;
  localparam int TXE = 1;
  localparam int OVR = 2;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/mmio_spi_slave_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, followed by an
// edge-detect flop that yields single-cycle rise/fall pulses.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_VAL    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {SYNC_STAGES{IDLE_VAL}};
      prev  <= IDLE_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/mmio_spi_slave.sv
// Bus-mapped SPI slave: TX/RX/STATUS register file on the core bus and a
// mode-0, MSB-first, fixed-length frame engine oversampling the SPI pins.
module mmio_spi_slave
  import mmio_spi_pkg::*;
#(
  parameter int WORD_BITS   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs,
  input  logic                 we,
  input  logic [31:0]          a,
  input  logic [WORD_BITS-1:0] wd,
  output logic [WORD_BITS-1:0] rd,
  output logic                 irq,
  input  logic                 spi_sclk,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso
);

  localparam int             CW       = $clog2(WORD_BITS + 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WORD_BITS - 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(WORD_BITS);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (spi_sclk),
    .level    (sclk_level_unused),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_cs_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (spi_cs_n),
    .level    (cs_level),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  logic unused_addr;
  assign unused_addr = ^{a[31:4], a[1:0]};

  logic [SYNC_STAGES-1:0] mosi_dly;
  logic [SYNC_STAGES-1:0] flush;
  logic                   armed;
  logic                   mosi_s;

  // A cs_n fall is only trusted once the synchronizer holds real samples and
  // has seen the line high; a frame already running at reset release is skipped.
  always_ff @(posedge clk) begin
    if (reset) begin
      mosi_dly <= '0;
      flush    <= '0;
      armed    <= 1'b0;
    end else begin
      mosi_dly <= {mosi_dly[SYNC_STAGES-2:0], spi_mosi};
      flush    <= {flush[SYNC_STAGES-2:0], 1'b1};
      if (flush[SYNC_STAGES-1] && cs_level) armed <= 1'b1;
    end
  end

  assign mosi_s = mosi_dly[SYNC_STAGES-1];

  state_t               state, next_state;
  logic [CW-1:0]        bitcnt;
  logic [WORD_BITS-2:0] tx_shift;
  logic [WORD_BITS-2:0] rx_shift;
  logic [WORD_BITS-1:0] rx_word;
  logic [WORD_BITS-1:0] tx_data, rx_data;
  logic                 rx_valid, overrun, tx_empty;
  logic                 frame_start, frame_stop, bit_rise, bit_fall, word_done;

  always_comb begin
    next_state  = state;
    frame_start = 1'b0;
    frame_stop  = 1'b0;
    bit_rise    = 1'b0;
    bit_fall    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall && armed) begin
          frame_start = 1'b1;
          next_state  = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          frame_stop = 1'b1;
          next_state = IDLE;
        end else if (bitcnt != CNT_FULL) begin
          bit_rise = sclk_rise;
          bit_fall = sclk_fall;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign word_done = bit_rise && (bitcnt == CNT_LAST);
  assign rx_word   = {rx_shift, mosi_s};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // spi_miso carries the current bit; tx_shift holds the bits still to go.
  always_ff @(posedge clk) begin
    if (reset) begin
      bitcnt   <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      spi_miso <= 1'b0;
    end else if (frame_start) begin
      bitcnt   <= '0;
      tx_shift <= tx_data[WORD_BITS-2:0];
      spi_miso <= tx_data[WORD_BITS-1];
    end else if (frame_stop) begin
      spi_miso <= 1'b0;
    end else begin
      if (bit_rise) begin
        rx_shift <= rx_word[WORD_BITS-2:0];
        bitcnt   <= bitcnt + CNT_ONE;
      end
      if (bit_fall) begin
        tx_shift <= {tx_shift[WORD_BITS-3:0], 1'b0};
        spi_miso <= tx_shift[WORD_BITS-2];
      end
    end
  end

  logic [1:0] reg_idx;
  logic       tx_wr, st_wr;

  assign reg_idx = a[3:2];
  assign tx_wr   = cs && we && (reg_idx == TXDATA);
  assign st_wr   = cs && we && (reg_idx == STATUS);

  // Hardware set beats W1C; a TXDATA write beats the frame-start empty flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      tx_empty <= 1'b1;
    end else begin
      if (tx_wr) tx_data <= wd;

      if (tx_wr)            tx_empty <= 1'b0;
      else if (frame_start) tx_empty <= 1'b1;

      if (word_done) rx_data <= rx_word;

      if (word_done)                 rx_valid <= 1'b1;
      else if (st_wr && wd[RXV])     rx_valid <= 1'b0;

      if (word_done && rx_valid)     overrun <= 1'b1;
      else if (st_wr && wd[OVR])     overrun <= 1'b0;
    end
  end

  always_comb begin
    rd = '0;
    case (reg_idx)
      TXDATA: rd = tx_data;
      RXDATA: rd = rx_data;
      STATUS: begin
        rd[RXV] = rx_valid;
        rd[TXE] = tx_empty;
        rd[OVR] = overrun;
      end
      default: rd = '0;
    endcase
  end

  assign irq = rx_valid;

endmodule
